prog_lut_gate: RTL and testbench

- Programmable N-input truth-table function block: e = TABLE[a], f = e & d.
- Generalises fixed-table, purely combinational function circuits. The table is runtime-reloadable through a serial configuration port, and the result is registered behind a valid/ready handshake.
- Sits between an operand source and a consumer in the lab datapath.
- The table is reloaded without glitching in-flight results.

---
 rtl/prog_lut_pkg.sv | 26 ++
 rtl/prog_lut_cfg_loader.sv | 94 +++++++++
 rtl/prog_lut_gate.sv | 114 +++++++++++
 tb/tb_prog_lut_gate.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_lut_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_lut_pkg
// Purpose  : Shared definitions for the programmable truth-table gate:
//            state encoding of the configuration FSM, legal range of the
//            function input count and the table width derivation.
// Revision : 1.0  initial release
// ============================================================================
package prog_lut_pkg;

    // Configuration FSM state encoding
    typedef logic state_t;
    localparam state_t ST_RUN  = 1'b0;   // evaluation enabled
    localparam state_t ST_LOAD = 1'b1;   // accepting table bits

    // Legal range of the number of function inputs
    localparam int c_N_IN_MIN = 1;
    localparam int c_N_IN_MAX = 6;

    // Truth-table width: one bit per minterm
    function automatic int tbl_w(input int n_in);
        return 1 << n_in;
    endfunction

endpackage : prog_lut_pkg
`default_nettype wire

// File: rtl/prog_lut_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_lut_cfg_loader
// Purpose  : Serial truth-table loader. Collects TBL_W bits (minterm 0
//            first) into a shadow register and presents the completed table
//            together with a one-cycle commit strobe on the final write.
// Ports    : clock, reset        - clock / async active-high reset
//            cfg_start           - begin or restart a load
//            cfg_valid, cfg_bit  - serial table bit and its qualifier
//            cfg_busy            - high while loading
//            cfg_done            - one-cycle pulse after a commit
//            o_new_table         - complete table, valid when o_commit = 1
//            o_commit            - combinational strobe, table lands this edge
// Revision : 1.0  initial release
// ============================================================================
module prog_lut_cfg_loader
    import prog_lut_pkg::*;
#(
    parameter int                 N_IN  = 3,
    parameter int                 TBL_W = 8,
    parameter logic [TBL_W-1:0]   INIT  = 8'hE3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic              cfg_bit,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic [TBL_W-1:0]  o_new_table,
    output logic              o_commit
);

    localparam logic [N_IN-1:0] c_CNT_LAST = N_IN'(TBL_W - 1);
    localparam logic [N_IN-1:0] c_CNT_ONE  = N_IN'(1);

    state_t             r_state;
    logic [N_IN-1:0]    r_cnt;
    logic [TBL_W-1:0]   r_shadow;
    logic               r_done;

    logic               w_write;
    logic               w_commit;
    logic [TBL_W-1:0]   w_new_table;

    // cfg_start outranks cfg_valid, so a restart cycle never writes a bit.
    assign w_write  = (r_state == ST_LOAD) && !cfg_start && cfg_valid;
    assign w_commit = w_write && (r_cnt == c_CNT_LAST);

    // The last bit is still on cfg_bit when committing, so merge it into the
    // shadow here; the top then captures the whole table in a single edge.
    always_comb begin
        w_new_table        = r_shadow;
        w_new_table[r_cnt] = cfg_bit;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_shadow <= INIT;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (r_state == ST_RUN) begin
                if (cfg_start) begin
                    r_state <= ST_LOAD;
                    r_cnt   <= '0;
                end
            end else begin
                if (cfg_start) begin
                    // Restart: partial shadow content is simply overwritten
                    // by the next full load.
                    r_cnt <= '0;
                end else if (w_write) begin
                    r_shadow[r_cnt] <= cfg_bit;
                    if (w_commit) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
            end
        end
    end

    assign cfg_busy    = (r_state == ST_LOAD);
    assign cfg_done    = r_done;
    assign o_new_table = w_new_table;
    assign o_commit    = w_commit;

endmodule : prog_lut_cfg_loader
`default_nettype wire

// File: rtl/prog_lut_gate.sv
`default_nettype none
// ============================================================================
// Module   : prog_lut_gate
// Purpose  : Programmable N_IN-input truth-table function with a registered,
//            valid/ready-handshaked result: e = TABLE[a], f = e & d.
//            The table is reloaded serially through the cfg_* port and
//            replaced atomically, so in-flight results keep old-table values.
// Ports    : clock, reset            - clock / async active-high reset
//            cfg_start/valid/bit     - serial table load port
//            cfg_busy, cfg_done      - load status / commit pulse
//            in_valid, in_ready      - operand handshake
//            a [N_IN-1:0], d         - minterm index and gate operand
//            out_valid, out_ready    - result handshake
//            e, f                    - registered TABLE[a] and TABLE[a] & d
// Revision : 1.0  initial release
// ============================================================================
module prog_lut_gate
    import prog_lut_pkg::*;
#(
    parameter int                      N_IN = 3,
    parameter logic [(1<<N_IN)-1:0]    INIT = 8'hE3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic              cfg_bit,
    output logic              cfg_busy,
    output logic              cfg_done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   a,
    input  logic              d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              e,
    output logic              f
);

    localparam int TBL_W = tbl_w(N_IN);

    generate
        if (N_IN < c_N_IN_MIN || N_IN > c_N_IN_MAX) begin : g_bad_n_in
            $error("prog_lut_gate: N_IN out of legal range 1..6");
        end
    endgenerate

    logic [TBL_W-1:0]   r_table;
    logic               r_out_valid;
    logic               r_e;
    logic               r_f;

    logic               w_busy;
    logic [TBL_W-1:0]   w_new_table;
    logic               w_commit;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_lut;

    prog_lut_cfg_loader #(
        .N_IN  (N_IN),
        .TBL_W (TBL_W),
        .INIT  (INIT)
    ) u_loader (
        .clock       (clock),
        .reset       (reset),
        .cfg_start   (cfg_start),
        .cfg_valid   (cfg_valid),
        .cfg_bit     (cfg_bit),
        .cfg_busy    (w_busy),
        .cfg_done    (cfg_done),
        .o_new_table (w_new_table),
        .o_commit    (w_commit)
    );

    // Operands are only taken in RUN; a stalled result blocks new ones.
    assign w_in_ready = !w_busy && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    // Lookup uses the table as registered at the accept edge; a commit can
    // never coincide with an accept because commits only happen in LOAD.
    assign w_lut = r_table[a];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_table <= INIT;
        end else if (w_commit) begin
            r_table <= w_new_table;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_e         <= 1'b0;
            r_f         <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_e         <= w_lut;
            r_f         <= w_lut & d;
        end else if (r_out_valid && out_ready) begin
            // Consumed with nothing behind it: drop valid, keep data.
            r_out_valid <= 1'b0;
        end
    end

    assign cfg_busy  = w_busy;
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign e         = r_e;
    assign f         = r_f;

endmodule : prog_lut_gate
`default_nettype wire

// File: tb/tb_prog_lut_gate.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_lut_gate
// Purpose  : Self-checking bench for prog_lut_gate (N_IN = 3, INIT = 8'hE3).
//            Table-driven sweep vectors plus directed multi-cycle sequences
//            for backpressure, table reload, restart, reset and pending
//            results across a load.
// Revision : 1.0  initial release
// ============================================================================
module tb_prog_lut_gate;

    typedef struct {
        logic [2:0] a;
        logic       d;
        logic       exp_e;
        logic       exp_f;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       cfg_busy;
    logic       cfg_done;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] a = 3'd0;
    logic       d = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       e;
    logic       f;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [16];

    prog_lut_gate #(
        .N_IN (3),
        .INIT (8'hE3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .e         (e),
        .f         (f)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue cfg_start for one cycle; optionally with a bit that must be ignored.
    task automatic start_load(input bit with_valid);
        cfg_start = 1'b1;
        cfg_valid = with_valid;
        cfg_bit   = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        chk("busy_after_start", cfg_busy, 1);
        chk("done_after_start", cfg_done, 0);
    endtask

    // Feed nbits of val (LSB first); optional idle gap before each bit.
    // When pend is set, a stalled result with value pend_e must stay put.
    task automatic feed(input logic [7:0] val, input int nbits, input bit gap,
                        input bit pend, input logic pend_e);
        for (int i = 0; i < nbits; i++) begin
            if (gap) begin
                cfg_valid = 1'b0;
                tick();
                chk("gap_busy", cfg_busy, 1);
            end
            cfg_valid = 1'b1;
            cfg_bit   = val[i];
            #1;
            chk("load_in_ready", in_ready, 0);
            chk("load_busy", cfg_busy, 1);
            chk("load_no_done", cfg_done, 0);
            if (pend) begin
                chk("pend_valid", out_valid, 1);
                chk("pend_e", e, pend_e);
            end
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    // Back-to-back sweep a = 0..7 with d, against expected table tbl.
    task automatic sweep(input logic [7:0] tbl, input logic dv);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        d         = dv;
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            #1;
            chk("sweep_in_ready", in_ready, 1);
            tick();
            chk("sweep_valid", out_valid, 1);
            chk("sweep_e", e, tbl[i]);
            chk("sweep_f", f, tbl[i] & dv);
        end
        in_valid = 1'b0;
        tick();
        chk("sweep_drain", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // INIT = 8'hE3 -> minterms 0,1,5,6,7 are 1
        vecs[0]  = '{3'd0, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{3'd1, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{3'd2, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'd3, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'd4, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'd5, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{3'd6, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{3'd7, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{3'd0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{3'd1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'd2, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'd3, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'd4, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'd5, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{3'd6, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{3'd7, 1'b0, 1'b1, 1'b0};

        // ---------------- reset state ----------------
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_e", e, 0);
        chk("rst_f", f, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_done", cfg_done, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // ---------------- tests 1/2: default-table sweeps ----------------
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = vecs[i].a;
            d = vecs[i].d;
            #1;
            chk("vec_in_ready", in_ready, 1);
            tick();
            chk("vec_valid", out_valid, 1);
            chk("vec_e", e, vecs[i].exp_e);
            chk("vec_f", f, vecs[i].exp_f);
        end
        in_valid = 1'b0;
        tick();
        chk("clear_valid", out_valid, 0);
        chk("clear_e_hold", e, 1);
        chk("clear_f_hold", f, 0);

        // ---------------- test 3: backpressure ----------------
        a = 3'd5; d = 1'b1; in_valid = 1'b1;
        tick();
        chk("bp_first_valid", out_valid, 1);
        chk("bp_first_e", e, 1);
        out_ready = 1'b0;
        a = 3'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_e", e, 1);
            chk("bp_hold_f", f, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_e", e, 0);
        chk("bp_next_f", f, 0);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", out_valid, 0);

        // ---------------- test 4: load 8'h96 with gaps ----------------
        start_load(1'b0);
        feed(8'h96, 8, 1'b1, 1'b0, 1'b0);
        chk("t4_done", cfg_done, 1);
        chk("t4_busy", cfg_busy, 0);
        tick();
        chk("t4_done_pulse", cfg_done, 0);
        sweep(8'h96, 1'b1);

        // ---------------- test 5a: restart mid-load ----------------
        start_load(1'b0);
        feed(8'h0F, 4, 1'b0, 1'b0, 1'b0);
        start_load(1'b1);   // restart with a bit that must be ignored
        feed(8'h01, 8, 1'b0, 1'b0, 1'b0);
        chk("t5a_done", cfg_done, 1);
        chk("t5a_busy", cfg_busy, 0);
        sweep(8'h01, 1'b1);

        // ---------------- test 5b: reset mid-load ----------------
        start_load(1'b0);
        feed(8'h00, 5, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("t5b_busy_async", cfg_busy, 0);
        chk("t5b_done_async", cfg_done, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5b_no_done", cfg_done, 0);
        end
        sweep(8'hE3, 1'b1);

        // ---------------- test 6: pending output across a load ----------------
        a = 3'd3; d = 1'b1; in_valid = 1'b1; out_ready = 1'b0; cfg_start = 1'b1;
        #1;
        chk("t6_accept_ready", in_ready, 1);
        tick();
        cfg_start = 1'b0;
        chk("t6_busy", cfg_busy, 1);
        chk("t6_valid", out_valid, 1);
        chk("t6_e_old", e, 0);
        feed(8'hFF, 8, 1'b0, 1'b1, 1'b0);
        chk("t6_done", cfg_done, 1);
        chk("t6_still_valid", out_valid, 1);
        chk("t6_still_e_old", e, 0);
        chk("t6_blocked", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("t6_ready_again", in_ready, 1);
        tick();
        chk("t6_new_valid", out_valid, 1);
        chk("t6_new_e", e, 1);
        chk("t6_new_f", f, 1);
        in_valid = 1'b0;
        tick();
        chk("t6_drain", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_prog_lut_gate
`default_nettype wire
